// File: rtl/banked_data_memory.sv
// Bank-interleaved data memory: NUM_READ_PORTS load ports plus one store/host write port
// served by NUM_BANKS single-ported banks, with per-bank round-robin arbitration and a clear-on-reset sequence.
module banked_data_memory #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int MEMORY_SIZE    = 1024,
  parameter int NUM_BANKS      = 4,
  parameter int NUM_READ_PORTS = 16
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     write_valid,
  output logic                                     write_ready,
  input  logic [ADDRESS_WIDTH-1:0]                 write_address,
  input  logic [DATA_WIDTH-1:0]                    write_data,
  input  logic [NUM_READ_PORTS-1:0]                read_valid,
  output logic [NUM_READ_PORTS-1:0]                read_ready,
  input  logic [NUM_READ_PORTS*ADDRESS_WIDTH-1:0]  read_address,
  output logic [NUM_READ_PORTS-1:0]                read_resp_valid,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]     read_data,
  output logic                                     init_busy,
  output logic                                     range_error
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int ROWS      = MEMORY_SIZE / NUM_BANKS;
  localparam int ROW_BITS  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PORT_BITS = (NUM_READ_PORTS > 1) ? $clog2(NUM_READ_PORTS) : 1;
  localparam logic [ADDRESS_WIDTH:0] MEM_LIMIT = (ADDRESS_WIDTH+1)'(MEMORY_SIZE);

  typedef logic [BANK_BITS-1:0] bank_t;
  typedef logic [ROW_BITS-1:0]  row_t;
  typedef logic [PORT_BITS-1:0] port_t;
  typedef enum logic {CLEAR, RUN} state_e;

  state_e state_q, state_d;
  row_t   clear_row_q, clear_row_d;
  logic   run;

  bank_t                     port_bank [NUM_READ_PORTS];
  row_t                      port_row  [NUM_READ_PORTS];
  logic [NUM_READ_PORTS-1:0] port_oor;
  bank_t                     write_bank;
  row_t                      write_row;
  logic                      write_oor;

  logic [NUM_BANKS-1:0]      bank_write_hit;
  logic [NUM_BANKS-1:0]      bank_grant;
  port_t                     bank_grant_port [NUM_BANKS];
  port_t                     rr_ptr_q [NUM_BANKS];
  logic [NUM_READ_PORTS-1:0] read_fire;
  logic                      write_fire;

  logic [DATA_WIDTH-1:0]     mem [NUM_BANKS][ROWS];
  logic [NUM_READ_PORTS-1:0] resp_valid_q;
  logic [DATA_WIDTH-1:0]     resp_data_q [NUM_READ_PORTS];
  logic                      range_error_q;

  function automatic port_t rr_index(input port_t ptr, input int offset);
    int s;
    s = int'(ptr) + offset;
    if (s >= NUM_READ_PORTS) s = s - NUM_READ_PORTS;
    return port_t'(s);
  endfunction

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values, independent of process order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CLEAR;
      clear_row_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_row_q <= clear_row_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    clear_row_d = clear_row_q;
    if (state_q == CLEAR) begin
      if (clear_row_q == row_t'(ROWS - 1)) begin
        state_d     = RUN;
        clear_row_d = '0;
      end else begin
        clear_row_d = clear_row_q + row_t'(1);
      end
    end
  end

  assign run       = (state_q == RUN);
  assign init_busy = (state_q == CLEAR);

  always_comb begin
    port_oor = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      port_bank[p] = read_address[p*ADDRESS_WIDTH +: BANK_BITS];
      port_row[p]  = read_address[p*ADDRESS_WIDTH + BANK_BITS +: ROW_BITS];
      port_oor[p]  = {1'b0, read_address[p*ADDRESS_WIDTH +: ADDRESS_WIDTH]} >= MEM_LIMIT;
    end
    write_bank = write_address[BANK_BITS-1:0];
    write_row  = write_address[BANK_BITS +: ROW_BITS];
    write_oor  = {1'b0, write_address} >= MEM_LIMIT;
  end

  // A write owns its bank for the cycle; otherwise each bank scans ports from its pointer.
  always_comb begin
    bank_write_hit = '0;
    bank_grant     = '0;
    read_ready     = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_grant_port[b] = '0;
      bank_write_hit[b]  = run && write_valid && (write_bank == bank_t'(b));
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < NUM_READ_PORTS; i++) begin
        if (run && !bank_write_hit[b] && !bank_grant[b] &&
            read_valid[rr_index(rr_ptr_q[b], i)] &&
            port_bank[rr_index(rr_ptr_q[b], i)] == bank_t'(b)) begin
          bank_grant[b]                      = 1'b1;
          bank_grant_port[b]                 = rr_index(rr_ptr_q[b], i);
          read_ready[rr_index(rr_ptr_q[b], i)] = 1'b1;
        end
      end
    end
  end

  assign write_ready = run && write_valid;
  assign write_fire  = write_valid && write_ready;
  assign read_fire   = read_valid & read_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) rr_ptr_q[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank_grant[b])
          rr_ptr_q[b] <= (bank_grant_port[b] == port_t'(NUM_READ_PORTS - 1)) ?
                         '0 : bank_grant_port[b] + port_t'(1);
      end
    end
  end

  // NOTE: the storage array has no reset; the CLEAR sequence zeroes it row by row instead.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      for (int b = 0; b < NUM_BANKS; b++) mem[b][clear_row_q] <= '0;
    end else if (write_fire && !write_oor) begin
      mem[write_bank][write_row] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_q  <= '0;
      range_error_q <= 1'b0;
      for (int p = 0; p < NUM_READ_PORTS; p++) resp_data_q[p] <= '0;
    end else begin
      resp_valid_q <= read_fire;
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
        if (read_fire[p])
          resp_data_q[p] <= port_oor[p] ? '0 : mem[port_bank[p]][port_row[p]];
      end
      if ((write_fire && write_oor) || |(read_fire & port_oor))
        range_error_q <= 1'b1;
    end
  end

  always_comb begin
    read_data = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++)
      read_data[p*DATA_WIDTH +: DATA_WIDTH] = resp_data_q[p];
  end

  assign read_resp_valid = resp_valid_q;
  assign range_error     = range_error_q;

endmodule

// File: tb/tb_banked_data_memory.sv
// Randomized and directed bench for banked_data_memory against an address-level reference model
// (flat word array, per-bank round-robin chosen by circular distance from the pointer).
module tb_banked_data_memory;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int MS = 64;
  localparam int NB = 4;
  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            write_valid;
  logic            write_ready;
  logic [AW-1:0]   write_address;
  logic [DW-1:0]   write_data;
  logic [NP-1:0]   read_valid;
  logic [NP-1:0]   read_ready;
  logic [NP*AW-1:0] read_address;
  logic [NP-1:0]   read_resp_valid;
  logic [NP*DW-1:0] read_data;
  logic            init_busy;
  logic            range_error;

  banked_data_memory #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEMORY_SIZE(MS),
    .NUM_BANKS(NB), .NUM_READ_PORTS(NP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .write_valid(write_valid), .write_ready(write_ready),
    .write_address(write_address), .write_data(write_data),
    .read_valid(read_valid), .read_ready(read_ready), .read_address(read_address),
    .read_resp_valid(read_resp_valid), .read_data(read_data),
    .init_busy(init_busy), .range_error(range_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_mem [MS];
  int          m_ptr [NB];
  logic [31:0] m_data [NP];
  logic        m_rerr;

  // Requester state (held until granted)
  logic        p_valid [NP];
  int          p_addr  [NP];
  logic        w_valid;
  int          w_addr;
  logic [31:0] w_data;
  logic [NP-1:0] obs_grant;

  task automatic model_reset();
    for (int i = 0; i < MS; i++) m_mem[i] = '0;
    for (int b = 0; b < NB; b++) m_ptr[b] = 0;
    for (int p = 0; p < NP; p++) begin
      m_data[p]  = '0;
      p_valid[p] = 1'b0;
      p_addr[p]  = 0;
    end
    m_rerr  = 1'b0;
    w_valid = 1'b0;
    w_addr  = 0;
    w_data  = '0;
  endtask

  task automatic drive();
    write_valid   = w_valid;
    write_address = AW'(w_addr);
    write_data    = w_data;
    for (int p = 0; p < NP; p++) begin
      read_valid[p]             = p_valid[p];
      read_address[p*AW +: AW]  = AW'(p_addr[p]);
    end
  endtask

  // One RUN cycle: predict grants/data, compare, clock, compare responses, retire granted requests.
  task automatic step();
    logic [NP-1:0] exp_g;
    drive();
    #2;
    exp_g = '0;
    for (int b = 0; b < NB; b++) begin
      int best;
      int bd;
      best = -1;
      bd   = NP;
      if (!(w_valid && (w_addr % NB) == b)) begin
        for (int p = 0; p < NP; p++) begin
          if (p_valid[p] && (p_addr[p] % NB) == b && ((p - m_ptr[b] + NP) % NP) < bd) begin
            bd   = (p - m_ptr[b] + NP) % NP;
            best = p;
          end
        end
      end
      if (best >= 0) begin
        exp_g[best] = 1'b1;
        m_ptr[b]    = (best + 1) % NP;
      end
    end
    check("write_ready", write_ready, w_valid);
    check("read_ready", read_ready, exp_g);
    obs_grant = read_ready;
    for (int p = 0; p < NP; p++) begin
      if (exp_g[p]) begin
        if (p_addr[p] < MS) m_data[p] = m_mem[p_addr[p]];
        else begin
          m_data[p] = '0;
          m_rerr    = 1'b1;
        end
      end
    end
    if (w_valid) begin
      if (w_addr < MS) m_mem[w_addr] = w_data;
      else m_rerr = 1'b1;
    end
    @(posedge clk);
    #1;
    check("resp_valid", read_resp_valid, exp_g);
    for (int p = 0; p < NP; p++)
      check($sformatf("read_data%0d", p), read_data[p*DW +: DW], m_data[p]);
    check("range_error", range_error, m_rerr);
    check("init_busy", init_busy, 1'b0);
    for (int p = 0; p < NP; p++) if (exp_g[p]) p_valid[p] = 1'b0;
    w_valid = 1'b0;
  endtask

  // Reset, then release with requests asserted: exactly 16 CLEAR cycles with no grants.
  task automatic do_init();
    reset_n = 1'b0;
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", init_busy, 1'b1);
    check("rst_wready", write_ready, 1'b0);
    check("rst_rready", read_ready, '0);
    check("rst_resp", read_resp_valid, '0);
    for (int p = 0; p < NP; p++) check("rst_data", read_data[p*DW +: DW], '0);
    check("rst_rerr", range_error, 1'b0);
    w_valid = 1'b1;
    w_addr  = 3;
    w_data  = 32'hFFFF_FFFF;
    for (int p = 0; p < NP; p++) begin
      p_valid[p] = 1'b1;
      p_addr[p]  = p;
    end
    drive();
    reset_n = 1'b1;
    for (int k = 0; k < MS / NB; k++) begin
      #2;
      check("clr_busy", init_busy, 1'b1);
      check("clr_wready", write_ready, 1'b0);
      check("clr_rready", read_ready, '0);
      @(posedge clk);
      #1;
    end
    model_reset();
    drive();
    check("clr_done", init_busy, 1'b0);
  endtask

  task automatic zero_sweep();
    for (int k = 0; k < MS / NB; k++) begin
      for (int p = 0; p < NP; p++) begin
        p_valid[p] = 1'b1;
        p_addr[p]  = k * NB + p;
      end
      step();
    end
  endtask

  int grant_q[$];
  int cyc;
  bit pending;

  initial begin
    reset_n = 1'b0;
    model_reset();
    drive();
    @(posedge clk);
    #1;
    do_init();

    // Four ports contend for bank 0
    p_addr[0] = 4; p_addr[1] = 8; p_addr[2] = 12; p_addr[3] = 16;
    for (int p = 0; p < NP; p++) p_valid[p] = 1'b1;
    cyc = 0;
    pending = 1'b1;
    while (pending && cyc < 8) begin
      step();
      for (int p = 0; p < NP; p++) if (obs_grant[p]) grant_q.push_back(p);
      pending = p_valid[0] | p_valid[1] | p_valid[2] | p_valid[3];
      cyc++;
    end
    check("contend_len", grant_q.size(), NP);
    for (int i = 0; i < grant_q.size() && i < NP; i++)
      check($sformatf("contend_order%0d", i), grant_q[i], i);

    zero_sweep();

    // Write then read-back on port 2
    w_valid = 1'b1; w_addr = 5; w_data = 32'hDEAD_BEEF;
    step();
    p_valid[2] = 1'b1; p_addr[2] = 5;
    step();
    check("deadbeef", read_data[2*DW +: DW], 32'hDEAD_BEEF);

    // Parallel reads across all banks
    for (int i = 0; i < NB; i++) begin
      w_valid = 1'b1; w_addr = i; w_data = $urandom;
      step();
    end
    for (int p = 0; p < NP; p++) begin
      p_valid[p] = 1'b1; p_addr[p] = p;
    end
    step();
    check("parallel_grant", obs_grant, 4'hF);

    // Write and read collide on bank 0
    w_valid = 1'b1; w_addr = 8; w_data = 32'h55;
    p_valid[1] = 1'b1; p_addr[1] = 8;
    step();
    check("collide_rr1", obs_grant[1], 1'b0);
    step();
    check("collide_data", read_data[1*DW +: DW], 32'h55);

    // Out-of-range read
    p_valid[0] = 1'b1; p_addr[0] = 70;
    step();
    check("oor_data", read_data[0 +: DW], 32'h0);
    check("oor_err", range_error, 1'b1);
    step();
    check("oor_sticky", range_error, 1'b1);

    // Randomized traffic with held requests
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (!p_valid[p] && $urandom_range(0, 99) < 60) begin
          p_valid[p] = 1'b1;
          p_addr[p]  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(64, 79))
                                                    : int'($urandom_range(0, 63));
        end
      end
      if ($urandom_range(0, 99) < 30) begin
        w_valid = 1'b1;
        w_addr  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(64, 79))
                                               : int'($urandom_range(0, 63));
        w_data  = $urandom;
      end
      step();
    end

    // Reset during RUN drops an in-flight response
    p_valid[0] = 1'b1; p_addr[0] = 5;
    drive();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_resp", read_resp_valid, '0);
    check("abort_data", read_data[0 +: DW], '0);
    check("abort_rerr", range_error, 1'b0);
    model_reset();
    drive();
    @(posedge clk);
    #1;

    // Reset during CLEAR row 7 restarts a full clear
    reset_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midclr_busy", init_busy, 1'b1);
    do_init();
    zero_sweep();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
